// File: rtl/usb_spi_xfer_engine_if.sv
// ---------------------------------------------------------------------------
// usb_spi_xfer_engine_if
// Bundles every non-clock/reset signal of usb_spi_xfer_engine.
//   master : host side (drives transfer control, TX writes, RX read address,
//            and the SPI MISO line from the slave device)
//   slave  : engine side (drives status, TX ready, RX read data, SPI outputs)
// Signals:
//   start, xfer_len[AW:0], cs_sel[CSW-1:0], cpol, cpha, clk_div[DIV_W-1:0]
//   wr_valid, wr_data[7:0], wr_ready          TX byte stream
//   rd_addr[AW-1:0], rd_data[7:0]             RX buffer read port
//   busy, done, rx_count[AW:0]                transfer status
//   spi_clk, spi_mosi, spi_csn[NUM_CS-1:0], spi_miso   SPI bus
// ---------------------------------------------------------------------------
interface usb_spi_xfer_engine_if #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned NUM_CS = 2,
  parameter int unsigned DIV_W  = 8
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic [AW:0]       xfer_len;
  logic [CSW-1:0]    cs_sel;
  logic              cpol;
  logic              cpha;
  logic [DIV_W-1:0]  clk_div;
  logic              wr_valid;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic [AW-1:0]     rd_addr;
  logic [7:0]        rd_data;
  logic              busy;
  logic              done;
  logic [AW:0]       rx_count;
  logic              spi_clk;
  logic              spi_mosi;
  logic [NUM_CS-1:0] spi_csn;
  logic              spi_miso;

  modport master (
    output start, xfer_len, cs_sel, cpol, cpha, clk_div,
    output wr_valid, wr_data, rd_addr, spi_miso,
    input  wr_ready, rd_data, busy, done, rx_count,
    input  spi_clk, spi_mosi, spi_csn
  );

  modport slave (
    input  start, xfer_len, cs_sel, cpol, cpha, clk_div,
    input  wr_valid, wr_data, rd_addr, spi_miso,
    output wr_ready, rd_data, busy, done, rx_count,
    output spi_clk, spi_mosi, spi_csn
  );
endinterface

// File: rtl/usb_spi_xfer_engine.sv
// ---------------------------------------------------------------------------
// usb_spi_xfer_engine
// Buffered SPI master. A transfer of up to DEPTH bytes is requested with
// start; TX bytes are streamed in through wr_valid/wr_ready and clocked out
// MSB-first as soon as they arrive (the engine stalls in WAIT with chip
// select held low if the TX stream runs dry). Received bytes land in an RX
// buffer readable through rd_addr/rd_data (1-cycle latency).
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    usb_spi_xfer_engine_if.slave (control, TX/RX buffers, status, SPI)
// ---------------------------------------------------------------------------
module usb_spi_xfer_engine #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned NUM_CS = 2,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  usb_spi_xfer_engine_if.slave    bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT, SHIFT, HOLD, DONE} state_e;

  state_e            state_q, state_d;
  logic [AW:0]       len_q, len_d;
  logic [CSW-1:0]    cs_q, cs_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [AW:0]       wr_cnt_q, wr_cnt_d;
  logic [AW:0]       tx_cnt_q, tx_cnt_d;
  logic [AW:0]       rx_cnt_q, rx_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [3:0]        edge_q, edge_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] csn_q, csn_d;

  logic [7:0]        tx_mem [DEPTH];
  logic [7:0]        rx_mem [DEPTH];
  logic [7:0]        rd_data_q;

  logic              wr_ready;
  logic              tx_we;
  logic              rx_we;
  logic [7:0]        rx_byte;
  logic [AW:0]       start_len;
  logic [AW:0]       tx_cnt_inc;

  assign tx_cnt_inc = tx_cnt_q + 1'b1;

  // Effective length: clamped to buffer depth, and an out-of-range chip
  // select turns the request into an empty transfer.
  always_comb begin
    start_len = bus.xfer_len;
    if (32'(bus.cs_sel) >= NUM_CS) begin
      start_len = '0;
    end else if (bus.xfer_len > LEN_MAX) begin
      start_len = LEN_MAX;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cs_d      = cs_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    wr_cnt_d  = wr_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    div_cnt_d = div_cnt_q;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    csn_d     = csn_q;
    rx_we     = 1'b0;
    rx_byte   = '0;

    wr_ready = (state_q != IDLE) && (state_q != DONE) && (wr_cnt_q < len_q);
    tx_we    = bus.wr_valid && wr_ready;
    if (tx_we) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        sclk_d = cpol_q;
        if (bus.start) begin
          len_d    = start_len;
          cs_d     = bus.cs_sel;
          cpol_d   = bus.cpol;
          cpha_d   = bus.cpha;
          div_d    = bus.clk_div;
          wr_cnt_d = '0;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          sclk_d   = bus.cpol;
          if (start_len == '0) begin
            state_d = DONE;
          end else begin
            for (int unsigned i = 0; i < NUM_CS; i++) begin
              if (bus.cs_sel == CSW'(i)) csn_d[i] = 1'b0;
            end
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        sclk_d = cpol_q;
        // Registered wr_count only: a write landing this cycle is picked up
        // on the next pass through WAIT.
        if (wr_cnt_q > tx_cnt_q) begin
          tx_sh_d   = tx_mem[tx_cnt_q[AW-1:0]];
          div_cnt_d = '0;
          edge_d    = '0;
          if (!cpha_q) mosi_d = tx_mem[tx_cnt_q[AW-1:0]][7];
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (div_cnt_q == div_q) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          edge_d    = edge_q + 4'd1;
          // Even edge index = leading edge, odd = trailing edge.
          if (!edge_q[0]) begin
            if (!cpha_q) begin
              rx_sh_d = {rx_sh_q[6:0], bus.spi_miso};
            end else begin
              mosi_d  = tx_sh_q[7];
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
          end else begin
            if (!cpha_q) begin
              mosi_d  = tx_sh_q[6];
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end else begin
              rx_sh_d = {rx_sh_q[6:0], bus.spi_miso};
            end
          end
          // The 16th toggle closes the byte; with cpha=1 the 8th sample is
          // taken on this same edge, so it is folded in directly.
          if (edge_q == 4'd15) begin
            rx_we    = 1'b1;
            rx_byte  = cpha_q ? {rx_sh_q[6:0], bus.spi_miso} : rx_sh_q;
            tx_cnt_d = tx_cnt_inc;
            rx_cnt_d = rx_cnt_q + 1'b1;
            state_d  = (tx_cnt_inc < len_q) ? WAIT : HOLD;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      HOLD: begin
        sclk_d = cpol_q;
        if (div_cnt_q == div_q) begin
          csn_d   = '1;
          state_d = DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      DONE: begin
        sclk_d  = cpol_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cs_q      <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      wr_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      div_cnt_q <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      csn_q     <= '1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cs_q      <= cs_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      wr_cnt_q  <= wr_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      div_cnt_q <= div_cnt_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      csn_q     <= csn_d;
    end
  end

  // Buffers carry no reset; only indices below rx_count are meaningful.
  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[wr_cnt_q[AW-1:0]] <= bus.wr_data;
    if (rx_we) rx_mem[tx_cnt_q[AW-1:0]] <= rx_byte;
    rd_data_q <= rx_mem[bus.rd_addr];
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.rx_count = rx_cnt_q;
  assign bus.spi_clk  = sclk_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.spi_csn  = csn_q;

  logic unused_cs;
  assign unused_cs = ^cs_q;
endmodule

// File: tb/tb_usb_spi_xfer_engine.sv
// ---------------------------------------------------------------------------
// tb_usb_spi_xfer_engine
// Directed bench for usb_spi_xfer_engine (DEPTH=64, NUM_CS=2, DIV_W=8).
// A negedge monitor tracks spi_clk edges, MOSI bits at rising spi_clk,
// half-period lengths, done pulses and chip-select integrity while busy.
// ---------------------------------------------------------------------------
module tb_usb_spi_xfer_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic miso_tie = 1'b0;
  always #5 clk = ~clk;

  usb_spi_xfer_engine_if #(.DEPTH(64), .NUM_CS(2), .DIV_W(8)) bus_if ();

  usb_spi_xfer_engine #(.DEPTH(64), .NUM_CS(2), .DIV_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  assign bus_if.spi_miso = miso_tie ? 1'b1 : bus_if.spi_mosi;

  int checks = 0;
  int failures = 0;

  logic        sclk_prev = 1'b0;
  int          rise_cnt, done_cnt, csn_bad, since_tog, hp_min, hp_max;
  bit          have_tog;
  logic [15:0] mosi_log;
  logic [1:0]  csn_exp = 2'b11;

  always @(negedge clk) begin
    since_tog++;
    if (bus_if.spi_clk !== sclk_prev) begin
      if (have_tog) begin
        if (since_tog < hp_min) hp_min = since_tog;
        if (since_tog > hp_max) hp_max = since_tog;
      end
      have_tog = 1'b1;
      since_tog = 0;
      if (bus_if.spi_clk === 1'b1) begin
        rise_cnt++;
        mosi_log = {mosi_log[14:0], bus_if.spi_mosi};
      end
    end
    sclk_prev = bus_if.spi_clk;
    if (bus_if.done === 1'b1) done_cnt++;
    if (bus_if.busy === 1'b1 && bus_if.done !== 1'b1 && bus_if.spi_csn !== csn_exp) csn_bad++;
  end

  task automatic clr_mon();
    rise_cnt = 0; done_cnt = 0; csn_bad = 0; have_tog = 1'b0;
    since_tog = 0; hp_min = 1000; hp_max = 0; mosi_log = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic start_xfer(input logic [6:0] len, input logic cs, input logic pol,
                            input logic pha, input logic [7:0] div);
    bus_if.xfer_len = len; bus_if.cs_sel = cs; bus_if.cpol = pol;
    bus_if.cpha = pha; bus_if.clk_div = div; bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus_if.wr_valid = 1'b1;
    bus_if.wr_data  = b;
    for (int i = 0; i < 200; i++) begin
      if (bus_if.wr_ready === 1'b1) begin
        @(posedge clk); #1;
        bus_if.wr_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus_if.wr_valid = 1'b0;
    checks++; failures++;
    $display("FAIL write_timeout data=%h wr_ready never rose within 200 cycles", b);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic read_rx(input logic [5:0] a, output logic [7:0] d);
    bus_if.rd_addr = a;
    @(posedge clk); #1;
    d = bus_if.rd_data;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus_if.done); end
    checks++; if (bus_if.wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready got=%b exp=0", bus_if.wr_ready); end
    checks++; if (bus_if.spi_csn !== 2'b11) begin failures++; $display("FAIL rst_csn got=%b exp=11", bus_if.spi_csn); end
    checks++; if (bus_if.spi_clk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", bus_if.spi_clk); end
    checks++; if (bus_if.spi_mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", bus_if.spi_mosi); end
    checks++; if (bus_if.rx_count !== 7'd0) begin failures++; $display("FAIL rst_rx_count got=%0d exp=0", bus_if.rx_count); end
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_mode0();
    bit ok; logic [7:0] d;
    csn_exp = 2'b10; miso_tie = 1'b0;
    start_xfer(7'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(1); clr_mon();
    write_byte(8'hA5); write_byte(8'h3C);
    wait_done(200, ok); idle(2);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL m0_done_seen got=%b exp=1", ok); end
    checks++; if (mosi_log !== 16'hA53C) begin failures++; $display("FAIL m0_mosi got=%h exp=a53c", mosi_log); end
    checks++; if (rise_cnt !== 16) begin failures++; $display("FAIL m0_rises got=%0d exp=16", rise_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL m0_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (csn_bad !== 0) begin failures++; $display("FAIL m0_csn_glitch got=%0d exp=0", csn_bad); end
    checks++; if (bus_if.rx_count !== 7'd2) begin failures++; $display("FAIL m0_rx_count got=%0d exp=2", bus_if.rx_count); end
    checks++; if (bus_if.spi_csn !== 2'b11) begin failures++; $display("FAIL m0_csn_end got=%b exp=11", bus_if.spi_csn); end
    read_rx(6'd0, d);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL m0_rx0 got=%h exp=a5", d); end
    read_rx(6'd1, d);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL m0_rx1 got=%h exp=3c", d); end
  endtask

  task automatic test_mode3();
    bit ok; logic [7:0] d;
    csn_exp = 2'b01; miso_tie = 1'b1;
    start_xfer(7'd1, 1'b1, 1'b1, 1'b1, 8'd3);
    idle(1);
    checks++; if (bus_if.spi_clk !== 1'b1) begin failures++; $display("FAIL m3_sclk_idle got=%b exp=1", bus_if.spi_clk); end
    clr_mon();
    write_byte(8'h5A);
    wait_done(400, ok); idle(2);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL m3_done_seen got=%b exp=1", ok); end
    checks++; if (hp_min !== 4 || hp_max !== 4) begin failures++; $display("FAIL m3_half_period got=%0d..%0d exp=4..4", hp_min, hp_max); end
    checks++; if (rise_cnt !== 8) begin failures++; $display("FAIL m3_rises got=%0d exp=8", rise_cnt); end
    checks++; if (csn_bad !== 0) begin failures++; $display("FAIL m3_csn_sel got=%0d exp=0", csn_bad); end
    checks++; if (bus_if.spi_clk !== 1'b1) begin failures++; $display("FAIL m3_sclk_end got=%b exp=1", bus_if.spi_clk); end
    read_rx(6'd0, d);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL m3_rx0 got=%h exp=ff", d); end
    miso_tie = 1'b0;
  endtask

  task automatic test_underrun();
    bit ok; logic [7:0] d;
    csn_exp = 2'b10;
    start_xfer(7'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(1); clr_mon();
    write_byte(8'h11);
    idle(50);
    checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL ur_busy got=%b exp=1", bus_if.busy); end
    checks++; if (bus_if.spi_clk !== 1'b0) begin failures++; $display("FAIL ur_sclk_gap got=%b exp=0", bus_if.spi_clk); end
    checks++; if (bus_if.spi_csn !== 2'b10) begin failures++; $display("FAIL ur_csn_gap got=%b exp=10", bus_if.spi_csn); end
    checks++; if (bus_if.rx_count !== 7'd1) begin failures++; $display("FAIL ur_rx_gap got=%0d exp=1", bus_if.rx_count); end
    write_byte(8'h22); write_byte(8'h33);
    wait_done(300, ok); idle(2);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ur_done_seen got=%b exp=1", ok); end
    checks++; if (rise_cnt !== 24) begin failures++; $display("FAIL ur_rises got=%0d exp=24", rise_cnt); end
    checks++; if (bus_if.rx_count !== 7'd3) begin failures++; $display("FAIL ur_rx_count got=%0d exp=3", bus_if.rx_count); end
    checks++; if (csn_bad !== 0) begin failures++; $display("FAIL ur_csn_glitch got=%0d exp=0", csn_bad); end
    read_rx(6'd1, d);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL ur_rx1 got=%h exp=22", d); end
  endtask

  task automatic test_len_limits();
    bit ok; logic [7:0] d;
    csn_exp = 2'b11;
    start_xfer(7'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    checks++; if (bus_if.done !== 1'b1) begin failures++; $display("FAIL l0_done got=%b exp=1", bus_if.done); end
    checks++; if (bus_if.spi_csn !== 2'b11) begin failures++; $display("FAIL l0_csn got=%b exp=11", bus_if.spi_csn); end
    idle(1);
    checks++; if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin failures++; $display("FAIL l0_after got=done%b/busy%b exp=done0/busy0", bus_if.done, bus_if.busy); end
    csn_exp = 2'b10;
    start_xfer(7'd65, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(1); clr_mon();
    for (int i = 0; i < 64; i++) write_byte(8'(i * 7 + 3));
    checks++; if (bus_if.wr_ready !== 1'b0) begin failures++; $display("FAIL lmax_wr_ready got=%b exp=0", bus_if.wr_ready); end
    wait_done(2000, ok); idle(2);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lmax_done_seen got=%b exp=1", ok); end
    checks++; if (rise_cnt !== 512) begin failures++; $display("FAIL lmax_rises got=%0d exp=512", rise_cnt); end
    checks++; if (bus_if.rx_count !== 7'd64) begin failures++; $display("FAIL lmax_rx_count got=%0d exp=64", bus_if.rx_count); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL lmax_done_pulses got=%0d exp=1", done_cnt); end
    read_rx(6'd0, d);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL lmax_rx0 got=%h exp=03", d); end
    read_rx(6'd63, d);
    checks++; if (d !== 8'hBC) begin failures++; $display("FAIL lmax_rx63 got=%h exp=bc", d); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [7:0] d;
    csn_exp = 2'b10;
    start_xfer(7'd1, 1'b0, 1'b0, 1'b0, 8'd3);
    idle(1); clr_mon();
    write_byte(8'h5A);
    idle(10);
    checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL rm_pre_busy got=%b exp=1", bus_if.busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus_if.spi_csn !== 2'b11) begin failures++; $display("FAIL rm_csn got=%b exp=11", bus_if.spi_csn); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL rm_done got=%b exp=0", bus_if.done); end
    checks++; if (bus_if.spi_clk !== 1'b0) begin failures++; $display("FAIL rm_sclk got=%b exp=0", bus_if.spi_clk); end
    @(posedge clk); #1;
    reset = 1'b1;
    idle(3);
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rm_no_done got=%0d exp=0", done_cnt); end
    checks++; if (bus_if.rx_count !== 7'd0) begin failures++; $display("FAIL rm_rx_count got=%0d exp=0", bus_if.rx_count); end
    start_xfer(7'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(1); clr_mon();
    write_byte(8'h96);
    wait_done(100, ok); idle(2);
    checks++; if (ok !== 1'b1 || done_cnt !== 1) begin failures++; $display("FAIL rm_restart_done got=ok%b/pulses%0d exp=ok1/pulses1", ok, done_cnt); end
    read_rx(6'd0, d);
    checks++; if (d !== 8'h96) begin failures++; $display("FAIL rm_restart_rx0 got=%h exp=96", d); end
  endtask

  task automatic test_start_busy();
    bit ok;
    csn_exp = 2'b10;
    start_xfer(7'd2, 1'b0, 1'b0, 1'b0, 8'd1);
    idle(1); clr_mon();
    start_xfer(7'd1, 1'b1, 1'b1, 1'b1, 8'd5);
    checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL sb_busy got=%b exp=1", bus_if.busy); end
    checks++; if (bus_if.spi_csn !== 2'b10) begin failures++; $display("FAIL sb_csn got=%b exp=10", bus_if.spi_csn); end
    checks++; if (bus_if.spi_clk !== 1'b0) begin failures++; $display("FAIL sb_sclk got=%b exp=0", bus_if.spi_clk); end
    write_byte(8'hC3); write_byte(8'h81);
    wait_done(300, ok); idle(2);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sb_done_seen got=%b exp=1", ok); end
    checks++; if (bus_if.rx_count !== 7'd2) begin failures++; $display("FAIL sb_rx_count got=%0d exp=2", bus_if.rx_count); end
    checks++; if (mosi_log !== 16'hC381) begin failures++; $display("FAIL sb_mosi got=%h exp=c381", mosi_log); end
    checks++; if (rise_cnt !== 16) begin failures++; $display("FAIL sb_rises got=%0d exp=16", rise_cnt); end
    checks++; if (bus_if.spi_clk !== 1'b0) begin failures++; $display("FAIL sb_sclk_end got=%b exp=0", bus_if.spi_clk); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL sb_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    bus_if.start = 1'b0; bus_if.xfer_len = '0; bus_if.cs_sel = '0;
    bus_if.cpol = 1'b0; bus_if.cpha = 1'b0; bus_if.clk_div = '0;
    bus_if.wr_valid = 1'b0; bus_if.wr_data = '0; bus_if.rd_addr = '0;
    clr_mon();
    test_reset();
    test_mode0();
    test_mode3();
    test_underrun();
    test_len_limits();
    test_reset_mid();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded 500000 time units");
    $fatal(1);
  end
endmodule

// File: doc/usb_spi_xfer_engine.md
USB_SPI_XFER_ENGINE -- requirements
Module: usb_spi_xfer_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 64: byte depth of each of the TX and RX buffers, power of two, 4..256.
REQ-002 SHALL have parameter NUM_CS, default 2: number of chip selects, 1..4.
REQ-003 SHALL have parameter DIV_W, default 8: width of clk_div.
REQ-004 SHALL derive AW = log2(DEPTH) and CSW = max(1, ceil(log2(NUM_CS))).
REQ-005 clk  in  1  single system clock, all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 start  in  1  one-cycle request to begin a transfer.
REQ-008 xfer_len  in  AW+1  byte count for the transfer.
REQ-009 cs_sel  in  CSW  chip-select index.
REQ-010 cpol, cpha  in  1 each  SPI mode bits.
REQ-011 clk_div  in  DIV_W  SPI half-period is clk_div+1 clk cycles.
REQ-012 wr_valid  in  1; wr_data  in  8; wr_ready  out  1  TX byte stream, accepted when valid and ready are both high.
REQ-013 rd_addr  in  AW; rd_data  out  8  RX buffer read port.
REQ-014 busy  out  1; done  out  1; rx_count  out  AW+1  transfer status.
REQ-015 spi_clk  out  1; spi_mosi  out  1; spi_csn  out  NUM_CS; spi_miso  in  1  SPI bus.

Function
REQ-016 SHALL implement states IDLE, WAIT, SHIFT, HOLD, DONE.
REQ-017 start in IDLE SHALL latch the following, and start in any other state SHALL be ignored:
- len = min(xfer_len, DEPTH)
- cs_sel, cpol, cpha, clk_div
- clear wr_count, tx_count, rx_count
REQ-018 IDLE + start with len==0 SHALL go to DONE without asserting any spi_csn bit.
REQ-019 IDLE + start with len>0 SHALL drive spi_csn[cs_sel] low on the next cycle and enter WAIT.
REQ-020 cs_sel >= NUM_CS SHALL be treated as len==0.
REQ-021 wr_ready SHALL be (state != IDLE && state != DONE && wr_count < len).
REQ-022 Each accepted write SHALL store wr_data at TX[wr_count] and increment wr_count.
REQ-023 WAIT SHALL advance to SHIFT when wr_count > tx_count, loading TX[tx_count] into the shift register and putting bit 7 on spi_mosi when cpha==0.
REQ-024 WAIT SHALL hold spi_csn low and spi_clk == cpol indefinitely while the TX buffer is empty (underrun stall).
REQ-025 SHIFT SHALL clock 8 bits MSB-first using 16 spi_clk toggles, each half-period clk_div+1 cycles long.
REQ-026 cpha==0 SHALL sample spi_miso on the leading edge and shift mosi on the trailing edge.
REQ-027 cpha==1 SHALL shift mosi on the leading edge and sample on the trailing edge.
REQ-028 After the 8th sample, the assembled byte SHALL be written to RX[tx_count], and tx_count and rx_count SHALL increment in the same cycle.
REQ-029 After a byte, SHALL go to WAIT if tx_count < len, else to HOLD.
REQ-030 HOLD SHALL keep spi_csn low for one half-period, then drive all spi_csn high and enter DONE.
REQ-031 DONE SHALL pulse done for exactly one cycle and return to IDLE.
REQ-032 busy SHALL be high in every state except IDLE.
REQ-033 rd_data SHALL equal RX[rd_addr] registered, with 1-cycle latency, readable in any state.
REQ-034 Contents of rd_addr >= rx_count SHALL be undefined.
REQ-035 Buffer indices SHALL use AW bits; len==DEPTH SHALL fill indices 0..DEPTH-1 with no wrap or overwrite.
REQ-036 A write in the same cycle as a byte load SHALL be honoured; WAIT exit SHALL use the registered wr_count.
REQ-037 spi_clk SHALL be cpol whenever not in SHIFT.

Reset
REQ-038 Reset asserted SHALL immediately force:
- state IDLE
- busy=0, done=0, wr_ready=0
- spi_csn all 1, spi_clk=0, spi_mosi=0
- rx_count=0 and all counters 0
REQ-039 Reset SHALL act mid-transfer, aborting it without a done pulse.
REQ-040 Buffer contents need not be reset.
REQ-041 On reset release, latched cpol SHALL be 0.

Verification
REQ-042 Mode 0, clk_div=0, len=2, TX 0xA5,0x3C, MISO loopback -> mosi bits 10100101 00111100, RX[0]=0xA5, RX[1]=0x3C, rx_count=2, one done pulse, spi_csn[0] low the whole transfer.
REQ-043 Mode 3, clk_div=3, cs_sel=1, len=1, MISO tied 1 -> spi_clk idles 1, 4-cycle half-periods, only spi_csn[1] asserted, RX[0]=0xFF.
REQ-044 len=3 with the 2nd byte written 50 cycles late -> csn stays low, spi_clk==cpol during the gap, total 24 clock cycles of SHIFT edges, rx_count=3.
REQ-045 xfer_len=0, then xfer_len=DEPTH+1 -> first: done one cycle after start with no csn; second: exactly DEPTH bytes clocked and wr_ready low after DEPTH writes.
REQ-046 Reset asserted mid-byte -> same cycle: csn all high, busy=0, no done; a subsequent start works normally.
REQ-047 start pulsed while busy -> ignored, latched len and mode unchanged.
